axi_lite_initiator: RTL and testbench
=====================================

AXI_LITE_INITIATOR -- requirements
Module: axi_lite_initiator

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 SHALL have port aclk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port areset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr  input  AXI_ADDR_WIDTH  byte address.
REQ-009 SHALL have port cmd_wdata  input  AXI_DATA_WIDTH  write data; ignored for reads.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-012 SHALL have port rsp_rdata  output  AXI_DATA_WIDTH  read data; 0 for writes.
REQ-013 SHALL have port rsp_resp  output  2  captured BRESP or RRESP.
REQ-014 SHALL have port m_axi_awaddr  output  AXI_ADDR_WIDTH  write address.
REQ-015 SHALL have port m_axi_awvalid  output  1  write address valid.
REQ-016 SHALL have port m_axi_awready  input  1  write address ready.
REQ-017 SHALL have port m_axi_wdata  output  AXI_DATA_WIDTH  write data.
REQ-018 SHALL have port m_axi_wstrb  output  AXI_DATA_WIDTH/8  byte strobes, constant all ones.
REQ-019 SHALL have port m_axi_wvalid  output  1  write data valid.
REQ-020 SHALL have port m_axi_wready  input  1  write data ready.
REQ-021 SHALL have port m_axi_bresp  input  2  write response.
REQ-022 SHALL have port m_axi_bvalid  input  1  write response valid.
REQ-023 SHALL have port m_axi_bready  output  1  write response ready.
REQ-024 SHALL have port m_axi_araddr  output  AXI_ADDR_WIDTH  read address.
REQ-025 SHALL have port m_axi_arvalid  output  1  read address valid.
REQ-026 SHALL have port m_axi_arready  input  1  read address ready.
REQ-027 SHALL have port m_axi_rdata  input  AXI_DATA_WIDTH  read data.
REQ-028 SHALL have port m_axi_rresp  input  2  read response.
REQ-029 SHALL have port m_axi_rvalid  input  1  read data valid.
REQ-030 SHALL have port m_axi_rready  output  1  read data ready.

Function
REQ-031 SHALL implement states IDLE, WADDR, WRESP, RADDR, RDATA, RSP; exactly one transaction outstanding.
REQ-032 SHALL drive cmd_ready=1 only in IDLE; on accept, latch cmd_addr/cmd_wdata/cmd_write and go to WADDR (write) or RADDR (read).
REQ-033 SHALL, in WADDR, drive awvalid and wvalid from registers starting the cycle after accept; each drops the cycle after its own handshake, independently; payload stable while valid.
REQ-034 SHALL enter WRESP once both AW and W handshakes have occurred (same cycle or any order); bready=1 only in WRESP; bvalid outside WRESP ignored.
REQ-035 SHALL, on bvalid&bready, capture bresp into rsp_resp, set rsp_rdata=0, go to RSP.
REQ-036 SHALL, in RADDR, hold arvalid=1 until arready, then go to RDATA; rready=1 only in RDATA.
REQ-037 SHALL, on rvalid&rready, capture rdata/rresp, go to RSP.
REQ-038 SHALL, in RSP, hold rsp_valid=1 with stable rsp_rdata/rsp_resp until rsp_ready, then return to IDLE (cmd_ready=1 the next cycle).
REQ-039 SHALL achieve minimum write latency 3 cycles accept-to-rsp_valid (AW/W at +1, B at +2, rsp_valid at +3) with zero-wait slave; same for reads.
REQ-040 SHALL pass non-OKAY responses (SLVERR/DECERR) unchanged, with no retry.

Reset
REQ-041 SHALL, while areset=1 (including mid-transaction), force IDLE, drive cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready to 0 and rsp_rdata/rsp_resp to 0, discarding any in-flight response; cmd_ready=1 the first cycle after release.

Verification
REQ-042 Write 0x10<-0xDEADBEEF, zero-wait slave, bresp=0 -> aw/w at +1, rsp_valid at +3, rsp_resp=0, rsp_rdata=0.
REQ-043 Read 0x04, arready delayed 3 cycles, rdata=0x12345678, rresp=0 -> arvalid held 4 cycles, rsp_rdata=0x12345678.
REQ-044 Write with wready 2 cycles before awready -> wvalid drops first, awvalid held, exactly one B handshake.
REQ-045 rsp_ready low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout; bresp=2 reported as rsp_resp=2.
REQ-046 areset pulsed in WRESP -> all valids/readies 0 next cycle, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_initiator.sv
// rtl/axi_lite_initiator.sv - single-outstanding AXI4-Lite initiator bridging a cmd/rsp handshake to AXI
module axi_lite_initiator #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;

  state_t                      state;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                        aw_fire;
  logic                        w_fire;
  logic                        aw_clear;
  logic                        w_clear;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = '1;

  // A channel counts as finished once its valid has dropped, so AW and W may complete in any order.
  assign aw_fire  = m_axi_awvalid && m_axi_awready;
  assign w_fire   = m_axi_wvalid && m_axi_wready;
  assign aw_clear = aw_fire || !m_axi_awvalid;
  assign w_clear  = w_fire || !m_axi_wvalid;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            if (cmd_write) begin
              wdata_q       <= cmd_wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WADDR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RADDR;
            end
          end
        end
        WADDR: begin
          if (aw_fire) m_axi_awvalid <= 1'b0;
          if (w_fire)  m_axi_wvalid  <= 1'b0;
          if (aw_clear && w_clear) begin
            m_axi_bready <= 1'b1;
            state        <= WRESP;
          end
        end
        WRESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_initiator.sv
// tb/tb_axi_lite_initiator.sv - directed self-checking bench for axi_lite_initiator
module tb_axi_lite_initiator;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axi_lite_initiator #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_slave();
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 0;
  endtask

  task automatic test_reset();
    areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    idle_slave();
    tick(); tick();
    n_checks++; if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}); end
    n_checks++; if ({rsp_rdata, rsp_resp} !== 34'h0) begin n_fail++; $display("FAIL reset_rsp: got %h expected 0", {rsp_rdata, rsp_resp}); end
    areset = 0;
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_read_delayed();
    idle_slave();
    issue(0, 32'h04, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h04 || rready !== 1'b0) begin n_fail++; $display("FAIL rd_arvalid_hold[%0d]: got arvalid=%b araddr=%h rready=%b expected 1 00000004 0", i, arvalid, araddr, rready); end
      if (i == 3) arready = 1;
      tick();
    end
    arready = 0;
    n_checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin n_fail++; $display("FAIL rd_after_ar: got arvalid=%b rready=%b expected 0 1", arvalid, rready); end
    rvalid = 1; rdata = 32'h1234_5678; rresp = 0;
    tick();
    rvalid = 0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_resp !== 2'd0 || rready !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got valid=%b rdata=%h resp=%0d rready=%b expected 1 12345678 0 0", rsp_valid, rsp_rdata, rsp_resp, rready); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_done: got rsp_valid=%b cmd_ready=%b expected 0 1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    idle_slave();
    awready = 1; wready = 1; bvalid = 1; bresp = 0;
    issue(1, 32'h10, 32'hDEAD_BEEF);
    n_checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_plus1_valids: got aw=%b w=%b cmd_ready=%b expected 1 1 0", awvalid, wvalid, cmd_ready); end
    n_checks++; if (awaddr !== 32'h10 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin n_fail++; $display("FAIL wr_payload: got %h %h %h expected 00000010 deadbeef f", awaddr, wdata, wstrb); end
    tick();
    n_checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_plus2: got aw=%b w=%b bready=%b rsp_valid=%b expected 0 0 1 0", awvalid, wvalid, bready, rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'd0 || rsp_rdata !== 32'h0 || bready !== 1'b0) begin n_fail++; $display("FAIL wr_plus3_rsp: got valid=%b resp=%0d rdata=%h bready=%b expected 1 0 00000000 0", rsp_valid, rsp_resp, rsp_rdata, bready); end
    idle_slave();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_done: got rsp_valid=%b cmd_ready=%b expected 0 1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_w_before_aw();
    int b_handshakes;
    idle_slave();
    b_handshakes = 0;
    issue(1, 32'h20, 32'h0BAD_F00D);
    wready = 1;
    tick();
    wready = 0;
    n_checks++; if (wvalid !== 1'b0 || awvalid !== 1'b1 || bready !== 1'b0) begin n_fail++; $display("FAIL ooo_w_first: got w=%b aw=%b bready=%b expected 0 1 0", wvalid, awvalid, bready); end
    tick();
    n_checks++; if (awvalid !== 1'b1 || awaddr !== 32'h20 || bready !== 1'b0) begin n_fail++; $display("FAIL ooo_aw_held: got aw=%b awaddr=%h bready=%b expected 1 00000020 0", awvalid, awaddr, bready); end
    awready = 1;
    tick();
    awready = 0;
    n_checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin n_fail++; $display("FAIL ooo_to_wresp: got aw=%b w=%b bready=%b expected 0 0 1", awvalid, wvalid, bready); end
    bvalid = 1; bresp = 0;
    for (int i = 0; i < 3; i++) begin
      if (bvalid && bready) b_handshakes++;
      tick();
    end
    bvalid = 0;
    n_checks++; if (b_handshakes !== 1 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ooo_one_b: got handshakes=%0d rsp_valid=%b expected 1 1", b_handshakes, rsp_valid); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_backpressure();
    idle_slave();
    awready = 1; wready = 1; bvalid = 1; bresp = 2;
    issue(1, 32'h30, 32'h5555_AAAA);
    tick(); tick();
    idle_slave();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'd2 || rsp_rdata !== 32'h0 || cmd_ready !== 1'b0 || arvalid !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b resp=%0d rdata=%h cmd_ready=%b arvalid=%b expected 1 2 00000000 0 0", i, rsp_valid, rsp_resp, rsp_rdata, cmd_ready, arvalid); end
      tick();
    end
    cmd_valid = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || arvalid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got rsp_valid=%b cmd_ready=%b arvalid=%b expected 0 1 0", rsp_valid, cmd_ready, arvalid); end
  endtask

  task automatic test_read_decerr();
    idle_slave();
    arready = 1; rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 3;
    issue(0, 32'h08, 32'h0);
    n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h08) begin n_fail++; $display("FAIL rd0_plus1: got arvalid=%b araddr=%h expected 1 00000008", arvalid, araddr); end
    tick();
    n_checks++; if (rready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd0_plus2: got rready=%b rsp_valid=%b expected 1 0", rready, rsp_valid); end
    tick();
    idle_slave();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || rsp_resp !== 2'd3) begin n_fail++; $display("FAIL rd0_decerr: got valid=%b rdata=%h resp=%0d expected 1 cafef00d 3", rsp_valid, rsp_rdata, rsp_resp); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_reset_mid();
    idle_slave();
    awready = 1; wready = 1;
    issue(1, 32'h50, 32'h1111_2222);
    tick();
    idle_slave();
    n_checks++; if (bready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_wresp: got bready=%b expected 1", bready); end
    areset = 1; bvalid = 1; bresp = 1;
    tick();
    bvalid = 0;
    n_checks++; if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 7'b0 || {rsp_rdata, rsp_resp} !== 34'h0) begin n_fail++; $display("FAIL rst_mid_clear: got ctrl=%b rsp=%h expected 0000000 0", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, {rsp_rdata, rsp_resp}); end
    areset = 0;
    tick();
    n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || bready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_release: got cmd_ready=%b rsp_valid=%b bready=%b expected 1 0 0", cmd_ready, rsp_valid, bready); end
  endtask

  initial begin
    test_reset();
    test_read_delayed();
    test_write_zero_wait();
    test_w_before_aw();
    test_backpressure();
    test_read_decerr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
